// File: rtl/reg_file_pkg.sv
// Shared register-file constants for the simpleCPU datapath: default geometry
// and the symbolic register indices decode uses.
package reg_file_pkg;
    localparam int REG_ADDR_W = 3;
    localparam int RF_N       = 8;
    localparam int RF_DEPTH   = 1 << REG_ADDR_W;

    typedef enum logic [REG_ADDR_W-1:0] {
        R0 = 3'd0, R1 = 3'd1, R2 = 3'd2, R3 = 3'd3,
        R4 = 3'd4, R5 = 3'd5, R6 = 3'd6, R7 = 3'd7
    } reg_idx_e;
endpackage

// File: rtl/reg_file_rf_read_port.sv
// One combinational read port: storage mux with zero-register and
// same-cycle write bypass overrides.
module rf_read_port #(
    parameter int N        = 8,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][N-1:0] mem,
    input  logic [AW-1:0]           rd_addr,
    input  logic                    wr_fire,
    input  logic [AW-1:0]           wr_addr,
    input  logic [N-1:0]            wr_data,
    output logic [N-1:0]            rd_data
);
    logic is_zero;
    logic hit;

    assign is_zero = (ZERO_REG != 0) && (rd_addr == '0);
    // A discarded write to entry 0 never bypasses because is_zero wins.
    assign hit     = (BYPASS != 0) && wr_fire && (rd_addr == wr_addr);

    always_comb begin
        rd_data = mem[rd_addr];
        if (is_zero)
            rd_data = '0;
        else if (hit)
            rd_data = wr_data;
    end
endmodule

// File: rtl/reg_file.sv
// General-purpose register file: one synchronous write port, two
// combinational read ports, bulk clear and a per-entry written bitmap.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int N        = RF_N,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [N-1:0]     wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [N-1:0]     rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [N-1:0]     rd_data_b,
    output logic [DEPTH-1:0] written
);
    logic [DEPTH-1:0][N-1:0] mem;
    logic                    wr_ok;
    logic                    wr_fire;

    // Entry 0 is never loaded when hardwired, so its flop stays at reset zero.
    assign wr_ok   = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    assign wr_fire = wr_en && !clear && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem     <= '0;
            written <= '0;
        end else if (clear) begin
            mem     <= '0;
            written <= '0;
        end else if (wr_ok) begin
            mem[wr_addr]     <= wr_data;
            written[wr_addr] <= 1'b1;
        end
    end

    rf_read_port #(.N(N), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_port_a (
        .mem     (mem),
        .rd_addr (rd_addr_a),
        .wr_fire (wr_fire),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data_a)
    );

    rf_read_port #(.N(N), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_port_b (
        .mem     (mem),
        .rd_addr (rd_addr_b),
        .wr_fire (wr_fire),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data_b)
    );
endmodule
